// File: rtl/jtopl_lfo.sv
// jtopl_lfo: vibrato phase counter and triangle tremolo generator, advanced once per sample.
module jtopl_lfo #(
  parameter int VIB_PW   = 10,
  parameter int AM_PW    = 6,
  parameter int AM_STEPS = 210
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       zero,
  input  logic       lfo_rst,
  input  logic       am_dep,
  output logic [2:0] vib_cnt,
  output logic [4:0] trem,
  output logic       vib_step,
  output logic       am_step
);
  logic [VIB_PW-1:0] vib_pre;
  logic [AM_PW-1:0]  am_pre;
  logic [7:0]        am_ph, am_nx, lvl;
  logic              am_up, tick, vib_wrap, am_wrap;
  always_comb begin
    tick     = cen & zero & ~lfo_rst;
    vib_wrap = tick & (&vib_pre);
    am_wrap  = tick & (&am_pre);
    am_nx    = (am_ph == 8'(AM_STEPS - 1)) ? 8'd0 : am_ph + 8'd1;
    // am_up tracks the rising half, so the falling half mirrors around the peak
    lvl      = am_up ? am_ph : 8'(AM_STEPS - 1) - am_ph;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vib_pre  <= '0;
      am_pre   <= '0;
      vib_cnt  <= '0;
      am_ph    <= '0;
      am_up    <= 1'b1;
      trem     <= '0;
      vib_step <= 1'b0;
      am_step  <= 1'b0;
    end else begin
      vib_step <= vib_wrap;
      am_step  <= am_wrap;
      if (cen && lfo_rst) begin
        vib_pre <= '0;
        am_pre  <= '0;
        vib_cnt <= '0;
        am_ph   <= '0;
        am_up   <= 1'b1;
        trem    <= '0;
      end else if (cen) begin
        trem <= am_dep ? 5'(lvl >> 2) : 5'(lvl >> 4);
        if (zero) begin
          vib_pre <= vib_pre + 1'b1;
          am_pre  <= am_pre + 1'b1;
          if (vib_wrap) vib_cnt <= vib_cnt + 3'd1;
          if (am_wrap) begin
            am_ph <= am_nx;
            am_up <= am_nx < 8'(AM_STEPS / 2);
          end
        end
      end
    end
endmodule
